// File: rtl/line_merge_engine.sv
// ---------------------------------------------------------------------------
// line_merge_engine
//   Sequential slide-and-merge engine for one row/column of a 2048 board.
//   A captured line of LEN tiles (log2 encoded, 0 = empty) is compacted toward
//   the slide target and equal neighbours are merged, at most once per tile.
//   One tile is examined per cycle; results appear with a one-cycle done pulse.
//
//   Handshake: start is a request sampled only while idle.  A start seen in
//   any other state is dropped, not queued.  done pulses for exactly one cycle
//   per accepted start, and every result output is valid from that cycle.  The
//   outputs then hold until the next result is produced.  Latency from the
//   accepting edge to done is LEN+2 cycles, and a new line can be accepted
//   every LEN+3 cycles.
//
// Ports
//   clk        clock
//   rst        synchronous reset, active-low
//   start      begin an operation (sampled in IDLE only)
//   reverse    0: slide toward tile 0, 1: slide toward tile LEN-1
//   line_in    packed input line, tile k at [k*VW +: VW]
//   line_out   packed result line, same packing
//   moved      result differs from the captured input line
//   merge_cnt  number of merges performed
//   score_add  sum of 2^(new code) over all merges, saturating
//   win_hit    some merge created code WIN_LEVEL
//   busy       operation in progress (SCAN/FLUSH)
//   done       one-cycle completion pulse
// ---------------------------------------------------------------------------
module line_merge_engine #(
    parameter int LEN       = 4,
    parameter int VW        = 4,
    parameter int SCORE_W   = 18,
    parameter int WIN_LEVEL = 11,
    localparam int MCW      = $clog2(LEN/2+1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                reverse,
    input  logic [LEN*VW-1:0]   line_in,
    output logic [LEN*VW-1:0]   line_out,
    output logic                moved,
    output logic [MCW-1:0]      merge_cnt,
    output logic [SCORE_W-1:0]  score_add,
    output logic                win_hit,
    output logic                busy,
    output logic                done
);

    localparam int I_W = (LEN > 1) ? $clog2(LEN) : 1;
    localparam int J_W = $clog2(LEN+1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state;
    logic [VW-1:0]       in_buf  [LEN];
    logic [VW-1:0]       out_buf [LEN];
    logic [LEN*VW-1:0]   orig_line;
    logic                rev_q;
    logic [I_W-1:0]      i;
    logic [J_W-1:0]      j;
    logic [VW-1:0]       hold;
    logic                hold_valid;

    // Scan-step datapath
    logic [VW-1:0]       cur_v;
    logic [VW-1:0]       nv;
    logic                do_merge;
    logic [I_W-1:0]      j_idx;
    logic [SCORE_W:0]    term;
    logic [SCORE_W:0]    sum;
    logic [SCORE_W-1:0]  score_next;
    logic [LEN*VW-1:0]   fin_line;

    always_comb begin
        cur_v    = in_buf[i];
        nv       = cur_v + 1'b1;
        // Max-code tiles never merge; this also keeps nv from wrapping.
        do_merge = hold_valid && (hold == cur_v) && (cur_v != '1);
        // j never reaches LEN while a write is pending, so the low bits suffice.
        j_idx    = j[I_W-1:0];
        // A term that cannot fit forces saturation through the carry bit.
        if (int'(nv) >= SCORE_W) begin
            term = '1;
        end else begin
            term = (SCORE_W+1)'(1) << nv;
        end
        sum        = {1'b0, score_add} + term;
        score_next = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
    end

    // Undo the capture-time reversal so the result is in line_in order.
    always_comb begin
        fin_line = '0;
        for (int k = 0; k < LEN; k++) begin
            fin_line[k*VW +: VW] = rev_q ? out_buf[LEN-1-k] : out_buf[k];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            orig_line  <= '0;
            rev_q      <= 1'b0;
            i          <= '0;
            j          <= '0;
            hold       <= '0;
            hold_valid <= 1'b0;
            for (int k = 0; k < LEN; k++) begin
                in_buf[k]  <= '0;
                out_buf[k] <= '0;
            end
            line_out   <= '0;
            moved      <= 1'b0;
            merge_cnt  <= '0;
            score_add  <= '0;
            win_hit    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        // Reversing on capture lets SCAN always slide toward index 0.
                        for (int k = 0; k < LEN; k++) begin
                            in_buf[k]  <= reverse ? line_in[(LEN-1-k)*VW +: VW]
                                                  : line_in[k*VW +: VW];
                            out_buf[k] <= '0;
                        end
                        orig_line  <= line_in;
                        rev_q      <= reverse;
                        i          <= '0;
                        j          <= '0;
                        hold_valid <= 1'b0;
                        merge_cnt  <= '0;
                        score_add  <= '0;
                        win_hit    <= 1'b0;
                        busy       <= 1'b1;
                        state      <= S_SCAN;
                    end
                end

                S_SCAN: begin
                    if (cur_v != '0) begin
                        if (!hold_valid) begin
                            hold       <= cur_v;
                            hold_valid <= 1'b1;
                        end else if (do_merge) begin
                            out_buf[j_idx] <= nv;
                            j              <= j + 1'b1;
                            hold_valid     <= 1'b0;
                            merge_cnt      <= merge_cnt + 1'b1;
                            score_add      <= score_next;
                            if (nv == VW'(WIN_LEVEL)) begin
                                win_hit <= 1'b1;
                            end
                        end else begin
                            out_buf[j_idx] <= hold;
                            j              <= j + 1'b1;
                            hold           <= cur_v;
                        end
                    end
                    if (i == I_W'(LEN-1)) begin
                        state <= S_FLUSH;
                    end else begin
                        i <= i + 1'b1;
                    end
                end

                S_FLUSH: begin
                    if (hold_valid) begin
                        out_buf[j_idx] <= hold;
                    end
                    hold_valid <= 1'b0;
                    busy       <= 1'b0;
                    state      <= S_DONE;
                end

                S_DONE: begin
                    line_out <= fin_line;
                    moved    <= (fin_line != orig_line);
                    done     <= 1'b1;
                    state    <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_line_merge_engine.sv
module tb_line_merge_engine;

    localparam int RW = 38;  // {line[15:0], moved, merge_cnt[1:0], score[17:0], win}

    logic        clk;
    logic        rst;
    logic        start;
    logic        reverse;
    logic [15:0] line_in;
    logic [15:0] line_out;
    logic        moved;
    logic [1:0]  merge_cnt;
    logic [17:0] score_add;
    logic        win_hit;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [RW-1:0] exp_q[$];
    int            done_t[$];

    line_merge_engine dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .reverse   (reverse),
        .line_in   (line_in),
        .line_out  (line_out),
        .moved     (moved),
        .merge_cnt (merge_cnt),
        .score_add (score_add),
        .win_hit   (win_hit),
        .busy      (busy),
        .done      (done)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] pack4(input int a, input int b, input int c, input int d);
        logic [15:0] r;
        r = {d[3:0], c[3:0], b[3:0], a[3:0]};
        return r;
    endfunction

    // Reference: gather non-zero tiles in slide order, then pair greedily.
    function automatic logic [RW-1:0] model(input logic [15:0] ln, input logic rev);
        int t[4];
        int o[4];
        int n, m, mc, sc, w, k, idx;
        logic [15:0] res;
        logic [3:0]  tv;
        n = 0; m = 0; mc = 0; sc = 0; w = 0;
        for (int q = 0; q < 4; q++) begin
            t[q] = 0;
            o[q] = 0;
        end
        for (int q = 0; q < 4; q++) begin
            idx = rev ? 3 - q : q;
            tv  = ln[idx*4 +: 4];
            if (tv != 0) begin
                t[n] = int'(tv);
                n++;
            end
        end
        k = 0;
        while (k < n) begin
            if (k + 1 < n && t[k] == t[k+1] && t[k] != 15) begin
                o[m] = t[k] + 1;
                mc++;
                sc += (1 << (t[k] + 1));
                if (t[k] + 1 == 11) w = 1;
                k += 2;
            end else begin
                o[m] = t[k];
                k++;
            end
            m++;
        end
        if (sc > 262143) sc = 262143;
        res = '0;
        for (int q = 0; q < 4; q++) begin
            idx = rev ? 3 - q : q;
            tv  = o[q][3:0];
            res[idx*4 +: 4] = tv;
        end
        return {res, (res != ln), mc[1:0], sc[17:0], w[0]};
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (done) begin
            logic [RW-1:0] e;
            done_t.push_back(cyc);
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("line_out",  line_out,  e[37:22]);
                chk("moved",     moved,     e[21]);
                chk("merge_cnt", merge_cnt, e[20:19]);
                chk("score_add", score_add, e[18:1]);
                chk("win_hit",   win_hit,   e[0]);
                chk("busy_at_done", busy, 0);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic send(input logic [15:0] ln, input logic rev, input logic check_lat);
        int t0;
        int lat;
        bit seen;
        @(negedge clk);
        line_in = ln;
        reverse = rev;
        start   = 1'b1;
        exp_q.push_back(model(ln, rev));
        @(negedge clk);
        start = 1'b0;
        t0    = cyc;
        seen  = 0;
        lat   = 0;
        for (int w = 0; w < 20; w++) begin
            @(negedge clk);
            // Disturb the inputs while busy; the captured line must be used.
            line_in = 16'($urandom);
            reverse = 1'($urandom);
            if (done) begin
                seen = 1;
                lat  = cyc - t0;
                break;
            end
        end
        chk("done_seen", seen, 1);
        if (check_lat) chk("latency", lat, 6);
    endtask

    function automatic int rnd_tile();
        int r;
        r = $urandom_range(0, 9);
        if (r <= 7) return $urandom_range(0, 3);
        if (r == 8) return 15;
        return 10;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int a0;
        int dcnt;
        rst     = 1'b0;
        start   = 1'b0;
        reverse = 1'b0;
        line_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_line_out",  line_out,  0);
        chk("rst_moved",     moved,     0);
        chk("rst_merge_cnt", merge_cnt, 0);
        chk("rst_score_add", score_add, 0);
        chk("rst_win_hit",   win_hit,   0);
        chk("rst_busy",      busy,      0);
        chk("rst_done",      done,      0);
        rst = 1'b1;

        // Directed cases
        send(pack4(1, 1, 2, 2),   1'b0, 1'b1);
        send(pack4(1, 1, 1, 0),   1'b0, 1'b1);
        send(pack4(2, 0, 0, 2),   1'b1, 1'b1);
        send(pack4(1, 2, 3, 4),   1'b0, 1'b1);
        send(pack4(15, 15, 0, 0), 1'b0, 1'b1);
        send(pack4(10, 10, 0, 0), 1'b0, 1'b1);
        send(pack4(0, 2, 2, 2),   1'b1, 1'b1);
        send(pack4(3, 3, 3, 3),   1'b1, 1'b1);
        send(pack4(0, 0, 0, 0),   1'b0, 1'b1);

        // Reset in the middle of SCAN: outputs clear, no done follows
        send(pack4(1, 1, 2, 2), 1'b0, 1'b0);
        @(negedge clk);
        line_in = pack4(3, 3, 1, 1);
        reverse = 1'b0;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy",      busy,      0);
        chk("midrst_line_out",  line_out,  0);
        chk("midrst_moved",     moved,     0);
        chk("midrst_merge_cnt", merge_cnt, 0);
        chk("midrst_score_add", score_add, 0);
        chk("midrst_win_hit",   win_hit,   0);
        chk("midrst_done",      done,      0);
        rst  = 1'b1;
        dcnt = 0;
        for (int w = 0; w < 10; w++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("midrst_no_done", dcnt, 0);
        send(pack4(2, 2, 0, 4), 1'b1, 1'b1);

        // Random lines
        for (int n = 0; n < 25; n++) begin
            send(pack4(rnd_tile(), rnd_tile(), rnd_tile(), rnd_tile()),
                 1'($urandom), 1'b1);
        end

        // start held high: accepts every 7 cycles, line_in noise ignored while busy
        @(negedge clk);
        done_t.delete();
        start = 1'b1;
        a0    = 0;
        for (int k = 0; k < 21; k++) begin
            if (k % 7 == 0) begin
                line_in = pack4(rnd_tile(), rnd_tile(), rnd_tile(), rnd_tile());
                reverse = 1'($urandom);
                exp_q.push_back(model(line_in, reverse));
            end else begin
                line_in = 16'($urandom);
                reverse = 1'($urandom);
            end
            @(negedge clk);
            if (k == 0) a0 = cyc;
        end
        start = 1'b0;
        repeat (10) @(negedge clk);
        chk("burst_done_count", done_t.size(), 3);
        if (done_t.size() == 3) begin
            chk("burst_first_lat", done_t[0] - a0, 6);
            chk("burst_gap1", done_t[1] - done_t[0], 7);
            chk("burst_gap2", done_t[2] - done_t[1], 7);
        end

        chk("exp_q_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1);
    end

endmodule
